// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
`timescale 1ns/1ps
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W  = 24;
    localparam int unsigned SDRAM_DATA_W  = 16;
    localparam int unsigned VID_BURST_LEN = 64;
    localparam int unsigned BURST_LEN_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } arb_state_t;

    // One requester's command fields, muxed as a unit onto the controller port.
    typedef struct packed {
        logic                    we;
        logic [BURST_LEN_W-1:0]  burst_len;
        logic [SDRAM_ADDR_W-1:0] addr_x16;
        logic [SDRAM_DATA_W-1:0] wdata;
        logic [1:0]              wmask;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-way SDRAM port arbiter: video burst reads have fixed priority, a
// starvation counter guarantees the CPU a slot. The grant is held from
// command issue until the owner pulses ack.
`timescale 1ns/1ps
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W        = sdram_pkg::SDRAM_ADDR_W,
    parameter int unsigned VID_BURST_LEN = sdram_pkg::VID_BURST_LEN,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // video scan-out
    input  logic              vid_cmd_valid,
    output logic              vid_cmd_ready,
    input  logic [ADDR_W-1:0] vid_addr_x16,
    output logic              vid_resp_valid,
    output logic [15:0]       vid_rdata,
    input  logic              vid_ack,
    // CPU bridge
    input  logic              cpu_cmd_valid,
    output logic              cpu_cmd_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr_x16,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_wmask,
    output logic              cpu_resp_valid,
    output logic [15:0]       cpu_rdata,
    input  logic              cpu_ack,
    // SDRAM controller
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_we,
    output logic [6:0]        mem_burst_len,
    output logic [ADDR_W-1:0] mem_addr_x16,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [15:0]       mem_rdata,
    output logic              mem_ack
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          state_q, state_d;
    logic                owner_vid_q, owner_vid_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic       starve_hit;
    logic       owner_valid;
    logic       owner_ack;
    sdram_cmd_t vid_cmd, cpu_cmd, sel_cmd;

    assign starve_hit  = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    assign owner_valid = owner_vid_q ? vid_cmd_valid : cpu_cmd_valid;
    assign owner_ack   = owner_vid_q ? vid_ack : cpu_ack;

    assign vid_cmd = '{we: 1'b0, burst_len: BURST_LEN_W'(VID_BURST_LEN),
                       addr_x16: vid_addr_x16, wdata: '0, wmask: '0};
    assign cpu_cmd = '{we: cpu_we, burst_len: BURST_LEN_W'(1),
                       addr_x16: cpu_addr_x16, wdata: cpu_wdata, wmask: cpu_wmask};
    assign sel_cmd = owner_vid_q ? vid_cmd : cpu_cmd;

    // State, owner and starvation registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_vid_q  <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_vid_q  <= owner_vid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant decision, command handshake tracking and release on owner ack.
    always_comb begin
        state_d      = state_q;
        owner_vid_d  = owner_vid_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (vid_cmd_valid && !(cpu_cmd_valid && starve_hit)) begin
                    owner_vid_d = 1'b1;
                    state_d     = CMD;
                    // Count only grants that make a waiting CPU wait longer.
                    if (!cpu_cmd_valid) begin
                        starve_cnt_d = '0;
                    end else if (!starve_hit) begin
                        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                    end
                end else if (cpu_cmd_valid) begin
                    owner_vid_d  = 1'b0;
                    state_d      = CMD;
                    starve_cnt_d = '0;
                end
            end
            CMD: begin
                // Owner withdrew its request: give the port back without issuing.
                if (!owner_valid) begin
                    state_d = IDLE;
                end else if (mem_cmd_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (owner_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command mux in CMD, response routing in DATA; everything else idles at 0.
    always_comb begin
        vid_cmd_ready  = 1'b0;
        cpu_cmd_ready  = 1'b0;
        vid_resp_valid = 1'b0;
        vid_rdata      = '0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = '0;
        mem_cmd_valid  = 1'b0;
        mem_we         = 1'b0;
        mem_burst_len  = '0;
        mem_addr_x16   = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        mem_ack        = 1'b0;
        unique case (state_q)
            CMD: begin
                mem_cmd_valid = owner_valid;
                mem_we        = sel_cmd.we;
                mem_burst_len = sel_cmd.burst_len;
                mem_addr_x16  = sel_cmd.addr_x16;
                mem_wdata     = sel_cmd.wdata;
                mem_wmask     = sel_cmd.wmask;
                if (owner_vid_q) begin
                    vid_cmd_ready = mem_cmd_ready;
                end else begin
                    cpu_cmd_ready = mem_cmd_ready;
                end
            end
            DATA: begin
                mem_ack = owner_ack;
                if (owner_vid_q) begin
                    vid_resp_valid = mem_resp_valid;
                    vid_rdata      = mem_rdata;
                end else begin
                    cpu_resp_valid = mem_resp_valid;
                    cpu_rdata      = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters:
  - the video scan-out engine, which issues 64-word burst reads once per visible line;
  - the CPU bus bridge, which issues single-word reads and writes.
- Video has fixed priority; a starvation counter guarantees the CPU a slot.
- Sits between both requesters and the SDRAM controller. It forwards the valid/ready command handshake, routes response words to the owner, and holds the grant until the owner pulses ack.

Parameters:
- ADDR_W, 24, word-address width (16-bit words).
- VID_BURST_LEN, 64, burst length driven on mem_burst_len for video commands.
- STARVE_LIMIT, 4, consecutive video grants allowed while a CPU request is pending.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- vid_cmd_valid  in  1  video read request; held until accepted.
- vid_cmd_ready  out  1  video command accepted.
- vid_addr_x16  in  ADDR_W  video burst start address.
- vid_resp_valid  out  1  video read word valid.
- vid_rdata  out  16  video read word.
- vid_ack  in  1  video transaction done (1-cycle pulse).
- cpu_cmd_valid  in  1  CPU request; held until accepted.
- cpu_cmd_ready  out  1  CPU command accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr_x16  in  ADDR_W  CPU word address.
- cpu_wdata  in  16  write data.
- cpu_wmask  in  2  byte enables.
- cpu_resp_valid  out  1  read data valid, or write completion.
- cpu_rdata  out  16  read word.
- cpu_ack  in  1  CPU transaction done (1-cycle pulse).
- mem_cmd_valid  out  1  command to SDRAM controller.
- mem_cmd_ready  in  1  controller accepts command.
- mem_we  out  1  write command.
- mem_burst_len  out  7  words per command: VID_BURST_LEN for video, 1 for CPU.
- mem_addr_x16  out  ADDR_W  command address.
- mem_wdata  out  16  write data.
- mem_wmask  out  2  byte enables.
- mem_resp_valid  in  1  response word / write completion.
- mem_rdata  in  16  response word.
- mem_ack  out  1  transaction done, forwarded from the owner.

Behaviour:
- FSM states: IDLE, CMD, DATA. Registered owner flag owner_vid; starvation counter starve_cnt (3 bits for the default).
- Reset: state=IDLE, owner_vid=0, starve_cnt=0. All outputs 0: ready, resp_valid, mem_cmd_valid, mem_ack. Data outputs are also 0.
- IDLE:
  - If vid_cmd_valid and not (cpu_cmd_valid and starve_cnt==STARVE_LIMIT): owner_vid<=1, go to CMD.
  - Else if cpu_cmd_valid: owner_vid<=0, go to CMD.
  - No request: stay in IDLE.
  - The decision is registered, so mem_cmd_valid rises exactly 1 cycle after the request is first seen in IDLE.
- CMD:
  - mem_* command fields are a combinational mux from the owner.
  - mem_cmd_valid = owner's cmd_valid.
  - Owner's cmd_ready = mem_cmd_ready. The non-owner's ready is 0.
  - On mem_cmd_valid && mem_cmd_ready, go to DATA.
  - If the owner drops cmd_valid before acceptance (protocol violation), return to IDLE with no command issued.
- DATA:
  - mem_resp_valid/mem_rdata are routed to the owner's resp_valid/rdata; the non-owner sees resp_valid=0.
  - mem_ack = owner's ack; the non-owner's ack is ignored.
  - On owner ack, go to IDLE. The earliest next command is 2 cycles after the ack cycle.
- Starvation counter update (on entering CMD):
  - Video grant while cpu_cmd_valid: starve_cnt+1, saturating at STARVE_LIMIT.
  - CPU grant: starve_cnt<=0.
  - Video grant with no CPU pending: starve_cnt<=0.
- Simultaneous requests: video wins unless starve_cnt==STARVE_LIMIT.
- Requests arriving while not in IDLE wait, ready=0. No queueing beyond the held valid.
- A response arriving in IDLE/CMD (spurious) is dropped; no resp_valid is asserted.
- Reset mid-transaction: FSM returns to IDLE at once. The SDRAM controller is reset by the same rst_i.
- No arithmetic on addresses: passed through unchanged, ADDR_W bits.

Decomposition:
- Shared package sdram_pkg holds:
  - localparams: SDRAM_ADDR_W=24, SDRAM_DATA_W=16, VID_BURST_LEN=64;
  - enum arb_state_t {IDLE, CMD, DATA};
  - typedef struct sdram_cmd_t {we, burst_len, addr_x16, wdata, wmask}, so the mux is a single struct select.
- No sub-module needed; the command mux and response router stay inline.

Test Plan:
- Video-only: vid_cmd_valid at cycle 10 -> mem_cmd_valid at 11 with addr 0x800000, burst 64. 64 words are routed to vid_rdata, cpu_resp_valid stays 0. vid_ack -> IDLE next cycle.
- CPU write only: cpu_we=1, addr 0x000123, wdata 0xBEEF, wmask 2'b11 -> mem_we=1 and fields match. One mem_resp_valid -> cpu_resp_valid=1. cpu_ack frees the bus.
- Simultaneous first requests from both -> video granted first; CPU cmd_ready stays 0 until after vid_ack, then CPU granted.
- Starvation: CPU held pending while video re-requests every transaction -> exactly 4 video grants, then the CPU is granted despite vid_cmd_valid=1; starve_cnt returns to 0.
- Reset during DATA (word 20 of a burst): rst_i 1 cycle -> all outputs 0 next cycle. Remaining mem_resp_valid words are not forwarded; a fresh request proceeds normally.
- Spurious mem_resp_valid in IDLE -> no resp_valid on either port, state unchanged.
